muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit for the EX stage of the 5-stage pipeline.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared funct3 codes, FSM encoding and operand-signedness helpers for muldiv_unit
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    // MUL is treated as unsigned: the low half of the product does not depend on signedness.
    function automatic logic rs1_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add (multiply) or restoring trial-subtract (divide) iteration
// Ports:
//   div_mode      1 = restoring divide step, 0 = shift-add multiply step
//   hi_in/hi_out  multiply: upper product half; divide: partial remainder
//   lo_in/lo_out  multiply: multiplier shifting out / product low half; divide: dividend shifting out / quotient
//   opnd          multiply: multiplicand magnitude; divide: divisor magnitude
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            div_mode,
    input  logic [XLEN-1:0] hi_in,
    input  logic [XLEN-1:0] lo_in,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, hi_in} + ({1'b0, opnd} & {(XLEN+1){lo_in[0]}});
        shifted = {hi_in, lo_in[XLEN-1]};
        diff    = shifted - {1'b0, opnd};
        hi_out  = sum[XLEN:1];
        lo_out  = {sum[0], lo_in[XLEN-1:1]};
        if (div_mode) begin
            // Remainder stays below the divisor, so a non-negative difference fits in XLEN bits.
            if (!diff[XLEN]) begin
                hi_out = diff[XLEN-1:0];
                lo_out = {lo_in[XLEN-2:0], 1'b1};
            end else begin
                hi_out = shifted[XLEN-1:0];
                lo_out = {lo_in[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with valid/ready result handshake and flush-kill
// Ports:
//   clk, reset_x            clock, asynchronous active-low reset
//   i_start/o_ready         request handshake; i_op funct3, i_rs1/i_rs2 operands, i_rd destination
//   i_kill                  flush: abort and drop everything, beats start and result acceptance
//   o_busy                  computing (CALC only)
//   o_valid/i_resultReady   result handshake for o_result/o_rd
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset_x,
    input  logic            i_start,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_rd,
    input  logic            i_kill,
    output logic            o_busy,
    output logic            o_valid,
    input  logic            i_resultReady,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd
);

    localparam int N     = XLEN / STEPS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    md_state_t         state, state_next;
    logic [2:0]        op_q;
    logic              sign_q;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   hi_q, lo_q, opnd_q;

    logic              accept, last_step;
    logic              neg1, neg2, sign_in;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_result;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, final_result;

    logic [XLEN-1:0]   hi_c [STEPS_PER_CYCLE+1];
    logic [XLEN-1:0]   lo_c [STEPS_PER_CYCLE+1];

    assign o_busy    = (state == ST_CALC);
    assign o_valid   = (state == ST_DONE);
    assign o_ready   = (state == ST_IDLE) || ((state == ST_DONE) && i_resultReady);
    assign accept    = i_start && o_ready && !i_kill;
    assign last_step = (state == ST_CALC) && (cnt == CNT_W'(1));

    // Operand conditioning at accept time: magnitudes, result sign and the short-circuit cases.
    always_comb begin
        neg1     = rs1_signed(i_op) && i_rs1[XLEN-1];
        neg2     = rs2_signed(i_op) && i_rs2[XLEN-1];
        mag1     = neg1 ? -i_rs1 : i_rs1;
        mag2     = neg2 ? -i_rs2 : i_rs2;
        // Remainder follows the dividend; everything else is the product/quotient sign.
        sign_in  = (i_op == MD_REM) ? neg1 : (neg1 ^ neg2);
        div_zero = i_op[2] && (i_rs2 == '0);
        div_ovf  = ((i_op == MD_DIV) || (i_op == MD_REM)) &&
                   (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);
        special  = div_zero || div_ovf;
        // op[1] separates REM/REMU from DIV/DIVU.
        if (div_zero) special_result = i_op[1] ? i_rs1 : '1;
        else          special_result = i_op[1] ? '0 : i_rs1;
    end

    assign hi_c[0] = hi_q;
    assign lo_c[0] = lo_q;

    for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .div_mode (op_q[2]),
            .hi_in    (hi_c[g]),
            .lo_in    (lo_c[g]),
            .opnd     (opnd_q),
            .hi_out   (hi_c[g+1]),
            .lo_out   (lo_c[g+1])
        );
    end

    // Sign fix-up applied to the chain output on the final CALC cycle.
    always_comb begin
        prod   = {hi_c[STEPS_PER_CYCLE], lo_c[STEPS_PER_CYCLE]};
        prod_s = sign_q ? -prod : prod;
        quot_s = sign_q ? -lo_c[STEPS_PER_CYCLE] : lo_c[STEPS_PER_CYCLE];
        rem_s  = sign_q ? -hi_c[STEPS_PER_CYCLE] : hi_c[STEPS_PER_CYCLE];
        case (op_q)
            MD_MUL:                       final_result = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: final_result = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              final_result = quot_s;
            default:                      final_result = rem_s;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = special ? ST_DONE : ST_CALC;
            ST_CALC: if (last_step) state_next = ST_DONE;
            ST_DONE: begin
                if (i_resultReady) begin
                    if (accept) state_next = special ? ST_DONE : ST_CALC;
                    else        state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (i_kill) state_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            op_q     <= MD_MUL;
            sign_q   <= 1'b0;
            cnt      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            o_result <= '0;
            o_rd     <= '0;
        end else if (accept) begin
            op_q   <= i_op;
            sign_q <= sign_in;
            o_rd   <= i_rd;
            cnt    <= CNT_W'(N);
            hi_q   <= '0;
            lo_q   <= mag1;
            opnd_q <= mag2;
            if (special) o_result <= special_result;
        end else if (state == ST_CALC) begin
            hi_q <= hi_c[STEPS_PER_CYCLE];
            lo_q <= lo_c[STEPS_PER_CYCLE];
            cnt  <= cnt - CNT_W'(1);
            if (last_step) o_result <= final_result;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit (radix 1 and radix 4 instances)
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_x;
    logic        i_start, i_kill, i_resultReady;
    logic [2:0]  i_op;
    logic [31:0] i_rs1, i_rs2;
    logic [4:0]  i_rd;

    logic        o_ready, o_busy, o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_rd;

    logic        r4_ready, r4_busy, r4_valid;
    logic [31:0] r4_result;
    logic [4:0]  r4_rd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .STEPS_PER_CYCLE(1)) dut (
        .clk(clk), .reset_x(reset_x), .i_start(i_start), .o_ready(o_ready),
        .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_kill(i_kill),
        .o_busy(o_busy), .o_valid(o_valid), .i_resultReady(i_resultReady),
        .o_result(o_result), .o_rd(o_rd)
    );

    muldiv_unit #(.XLEN(32), .STEPS_PER_CYCLE(4)) dut_r4 (
        .clk(clk), .reset_x(reset_x), .i_start(i_start), .o_ready(r4_ready),
        .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_kill(i_kill),
        .o_busy(r4_busy), .o_valid(r4_valid), .i_resultReady(i_resultReady),
        .o_result(r4_result), .o_rd(r4_rd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request; count edges from the accept edge (inclusive) until o_valid.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic with_ack, output int lat);
        @(negedge clk);
        i_op = op; i_rs1 = a; i_rs2 = b; i_rd = rd;
        i_start = 1'b1; i_resultReady = with_ack;
        lat = 0;
        do begin
            @(posedge clk); #1;
            i_start = 1'b0; i_resultReady = 1'b0;
            lat++;
        end while (!o_valid && lat < 100);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        i_resultReady = 1'b1;
        @(posedge clk); #1;
        i_resultReady = 1'b0;
        check({tag, "_ack_valid"}, {31'b0, o_valid}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(op, a, b, rd, 1'b0, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, o_result, exp);
        check({tag, "_rd"},  {27'b0, o_rd}, {27'b0, rd});
        consume(tag);
    endtask

    initial begin
        int lat, cnt;
        reset_x = 1'b0; i_start = 1'b0; i_kill = 1'b0; i_resultReady = 1'b0;
        i_op = 3'd0; i_rs1 = '0; i_rs2 = '0; i_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",  {31'b0, o_valid}, 32'd0);
        check("rst_busy",   {31'b0, o_busy},  32'd0);
        check("rst_ready",  {31'b0, o_ready}, 32'd1);
        check("rst_result", o_result, 32'd0);
        check("rst_rd",     {27'b0, o_rd}, 32'd0);
        @(negedge clk);
        reset_x = 1'b1;

        run("mul_7_m3",   3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33);
        run("mul_big",    3'd0, 32'h1234_5678, 32'h0000_0010, 5'd4,  32'h2345_6780, 33);
        run("mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000, 33);
        run("mulhu_min",  3'd3, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 33);
        run("mulhsu_m1",  3'd2, 32'hFFFF_FFFF, 32'd2,         5'd7,  32'hFFFF_FFFF, 33);
        run("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD, 33);
        run("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFF, 33);
        run("divu_100_7", 3'd5, 32'd100,       32'd7,         5'd10, 32'd14,        33);
        run("divu_z",     3'd5, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1);
        run("remu_z",     3'd7, 32'd5,         32'd0,         5'd12, 32'd5,         1);
        run("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
        run("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         1);

        // Radix-4 instance: N=8, so valid 9 clocks after accept.
        @(negedge clk);
        i_op = 3'd0; i_rs1 = 32'd7; i_rs2 = 32'hFFFF_FFFD; i_rd = 5'd21; i_start = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            i_start = 1'b0;
            lat++;
        end while (!r4_valid && lat < 100);
        check("r4_lat", lat, 9);
        check("r4_res", r4_result, 32'hFFFF_FFEB);
        check("r4_rd",  {27'b0, r4_rd}, 32'd21);
        cnt = 0;
        while (!o_valid && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("r4_base_res", o_result, 32'hFFFF_FFEB);
        consume("r4");

        // Kill in CALC cycle 10.
        @(negedge clk);
        i_op = 3'd0; i_rs1 = 32'd9; i_rs2 = 32'd9; i_rd = 5'd1; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("kill_busy_before", {31'b0, o_busy}, 32'd1);
        @(negedge clk);
        i_kill = 1'b1;
        @(posedge clk); #1;
        i_kill = 1'b0;
        check("kill_busy_after",  {31'b0, o_busy},  32'd0);
        check("kill_valid_after", {31'b0, o_valid}, 32'd0);
        cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (o_valid || o_busy) cnt++;
        end
        check("kill_no_result", cnt, 0);

        // Start together with kill is dropped.
        @(negedge clk);
        i_op = 3'd0; i_rs1 = 32'd3; i_rs2 = 32'd3; i_start = 1'b1; i_kill = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_kill = 1'b0;
        check("startkill_busy",  {31'b0, o_busy},  32'd0);
        check("startkill_valid", {31'b0, o_valid}, 32'd0);
        check("startkill_ready", {31'b0, o_ready}, 32'd1);

        // Backpressure: result and rd held while not accepted.
        issue(3'd0, 32'h1234_5678, 32'h0000_0010, 5'd17, 1'b0, lat);
        check("bp_lat", lat, 33);
        cnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (!o_valid || o_result !== 32'h2345_6780 || o_rd !== 5'd17) cnt++;
        end
        check("bp_stable", cnt, 0);
        check("bp_res", o_result, 32'h2345_6780);

        // Back-to-back: ack and new start in the same cycle.
        issue(3'd7, 32'd100, 32'd7, 5'd18, 1'b1, lat);
        check("b2b_lat", lat, 33);
        check("b2b_res", o_result, 32'd2);
        check("b2b_rd",  {27'b0, o_rd}, 32'd18);
        consume("b2b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
